// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core controller and the multiply/divide unit.
// The controller drives the master side; muldiv_unit sits on the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
// Sign-magnitude datapath: operands are made positive on entry, the result is fixed up in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               zero_div_q, zero_div_d;
  logic               prod_neg_q, prod_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_by_zero_q, div_by_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_div_d      = is_div_q;
    zero_div_d    = zero_div_q;
    prod_neg_d    = prod_neg_q;
    rem_neg_d     = rem_neg_q;
    opnd_d        = opnd_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    div_by_zero_d = 1'b0;
    hi_d          = hi_q;
    lo_d          = lo_q;

    signed_op = ~bus.op[0];
    a_abs     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply adds opnd into the upper half; divide keeps the quotient in acc's lower half.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod_fix  = prod_neg_q ? -acc_q : acc_q;
    quo_fix   = prod_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          is_div_d   = bus.op[1];
          zero_div_d = bus.op[1] && (bus.b == '0);
          prod_neg_d = signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rem_neg_d  = signed_op && bus.a[WIDTH-1];
          opnd_d     = bus.op[1] ? b_abs : a_abs;
          acc_d      = {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
          rem_d      = '0;
          cnt_d      = CNT_W'(WIDTH);
          busy_d     = 1'b1;
          state_d    = RUN;
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
          rem_d            = div_diff[WIDTH] ? div_shift : div_diff;
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor still runs all steps, leaving |a| in rem so the sign fix restores raw a.
        hi_d          = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d          = is_div_q ? (zero_div_q ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
        done_d        = 1'b1;
        div_by_zero_d = zero_div_q;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
    end
    // NOTE: the datapath is fully reloaded on every accepted start, so it carries no reset.
    cnt_q      <= cnt_d;
    is_div_q   <= is_div_d;
    zero_div_q <= zero_div_d;
    prod_neg_q <= prod_neg_d;
    rem_neg_q  <= rem_neg_d;
    opnd_q     <= opnd_d;
    acc_q      <= acc_d;
    rem_q      <= rem_d;
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a behavioural model queues expected HI/LO per start,
// a done-driven monitor pops and compares; latency, busy width and MTHI/MTLO are checked inline.
module tb_muldiv_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  res_t         sb_q[$];
  res_t         mon_e;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    int sa, sb;
    longint sp;
    longint unsigned up;
    sa = $signed(a);
    sb = $signed(b);
    r.dbz = 1'b0;
    r.hi  = '0;
    r.lo  = '0;
    if (op[1] && b == '0) begin
      r.hi  = a;
      r.lo  = '1;
      r.dbz = 1'b1;
    end else begin
      case (op)
        2'b00: begin sp = longint'(sa) * longint'(sb); {r.hi, r.lo} = sp; end
        2'b01: begin up = 64'(a) * 64'(b); {r.hi, r.lo} = up; end
        2'b10: begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.lo = a;
            r.hi = '0;
          end else begin
            r.lo = sa / sb;
            r.hi = sa % sb;
          end
        end
        default: begin r.lo = a / b; r.hi = a % b; end
      endcase
    end
    return r;
  endfunction

  // Every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_hi", bus.hi, mon_e.hi);
        check("result_lo", bus.lo, mon_e.lo);
        check("result_dbz", bus.div_by_zero, mon_e.dbz);
        model_hi = mon_e.hi;
        model_lo = mon_e.lo;
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen, so calls chain back-to-back.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    int cyc;
    int busy_cnt;
    bit seen;
    sb_q.push_back(model(op, a, b));
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    check("busy_after_start", bus.busy, 64'd1);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    cyc = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cnt++;
      if (poke && cyc == 5) begin
        bus.start = 1'b1;
        bus.op    = op ^ 2'b10;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end
      if (poke && cyc == 6) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("run_hi_hold", bus.hi, model_hi);
        check("run_lo_hold", bus.lo, model_lo);
      end
      if (bus.done) seen = 1'b1;
    end
    check("latency", 64'(cyc), 64'(W + 2));
    check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
  endtask

  task automatic write_hilo(input bit we_hi, input bit we_lo, input logic [W-1:0] data);
    bus.hi_we = we_hi;
    bus.lo_we = we_lo;
    bus.wdata = data;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (we_hi) model_hi = data;
    if (we_lo) model_lo = data;
    check("mt_hi", bus.hi, model_hi);
    check("mt_lo", bus.lo, model_lo);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 64'd0);
    check("reset_done", bus.done, 64'd0);
    check("reset_dbz", bus.div_by_zero, 64'd0);
    check("reset_hi", bus.hi, 64'd0);
    check("reset_lo", bus.lo, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'h0000_0007, 32'h0000_0000, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0);
    run_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);

    write_hilo(1'b0, 1'b1, 32'h1234_5678);
    write_hilo(1'b1, 1'b1, 32'hCAFE_F00D);
    run_op(2'b00, 32'h0000_1234, 32'hFFFF_0001, 1'b1);

    // Reset in the middle of RUN aborts with no result.
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'h0000_0077;
    bus.b     = 32'h0000_0099;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", bus.busy, 64'd0);
    check("abort_done", bus.done, 64'd0);
    check("abort_hi", bus.hi, 64'd0);
    check("abort_lo", bus.lo, 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle_busy", bus.busy, 64'd0);
    run_op(2'b11, 32'h0000_0064, 32'h0000_0007, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom_range(3)), $urandom, (i == 3) ? 32'd0 : $urandom, 1'b0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
